// File: rtl/fpaddsub_operand_stage.sv
// First stage of the FP add/sub pipeline: sorts operands by magnitude, derives the effective
// operation and result sign, and tracks in-flight operations. Optional macro: FPADDSUB_ZERO_DETECT_EN.
module fpaddsub_operand_stage #(
   parameter int W          = 32,
   parameter int EW         = 8,
   parameter int SW         = 23,
   parameter int PIPE_DEPTH = 4,
   localparam int CW        = $clog2(PIPE_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable_Pipeline_input,
   input  logic                  enable_shift_reg,
   input  logic [W-1:0]          Data_X,
   input  logic [W-1:0]          Data_Y,
   input  logic                  add_subt,
   output logic [W-1:0]          DMP_o,
   output logic [W-1:0]          DmP_o,
   output logic                  swap_o,
   output logic                  real_op_o,
   output logic                  sign_res_o,
   output logic [PIPE_DEPTH-1:0] valid_o,
   output logic                  ready_o,
   output logic                  busy_o,
   output logic [CW-1:0]         inflight_o,
   output logic                  overrun_o,
   output logic                  zero_res_o
);

   if (W != 1 + EW + SW) begin : g_bad_width
      $error("W must equal 1+EW+SW");
   end
   if (PIPE_DEPTH < 2 || PIPE_DEPTH > 8) begin : g_bad_depth
      $error("PIPE_DEPTH must be in 2..8");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1
   } state_t;

   localparam logic [CW-1:0] FULL = CW'(PIPE_DEPTH);

   state_t                  state;
   state_t                  state_next;
   logic                    full;
   logic                    load;
   logic                    refused;
   logic                    ready;
   logic                    swap;
   logic                    real_op;
   logic                    sign_res;
   logic [W-2:0]            mag_x;
   logic [W-2:0]            mag_y;
   logic [CW-1:0]           inflight_next;
   logic [PIPE_DEPTH-1:0]   valid_next;

   // Strobe handshake: a load is accepted on any edge where enable_Pipeline_input is high and
   // fewer than PIPE_DEPTH operations are in flight; ready_o is the matching completion pulse.
   assign full    = (inflight_o == FULL);
   assign load    = enable_Pipeline_input & ~full;
   assign refused = enable_Pipeline_input & full;
   assign ready   = enable_shift_reg & valid_o[PIPE_DEPTH-1];

   assign mag_x    = Data_X[W-2:0];
   assign mag_y    = Data_Y[W-2:0];
   assign swap     = (mag_y > mag_x);
   assign real_op  = Data_X[W-1] ^ Data_Y[W-1] ^ add_subt;
   assign sign_res = swap ? (Data_Y[W-1] ^ add_subt) : Data_X[W-1];

   always_comb begin
      inflight_next = inflight_o;
      if (load && !ready) begin
         inflight_next = inflight_o + CW'(1);
      end else if (ready && !load && (inflight_o != '0)) begin
         inflight_next = inflight_o - CW'(1);
      end
   end

   always_comb begin
      valid_next = valid_o;
      if (enable_shift_reg) begin
         valid_next = {valid_o[PIPE_DEPTH-2:0], load};
      end else if (load) begin
         valid_next[0] = 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (load) state_next = RUN;
         RUN:     if (inflight_next == '0) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy_o = (state == RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         DMP_o      <= '0;
         DmP_o      <= '0;
         swap_o     <= 1'b0;
         real_op_o  <= 1'b0;
         sign_res_o <= 1'b0;
         valid_o    <= '0;
         ready_o    <= 1'b0;
         inflight_o <= '0;
         overrun_o  <= 1'b0;
      end else begin
         state      <= state_next;
         valid_o    <= valid_next;
         ready_o    <= ready;
         inflight_o <= inflight_next;
         if (refused) begin
            overrun_o <= 1'b1;
         end
         if (load) begin
            DMP_o      <= swap ? Data_Y : Data_X;
            DmP_o      <= swap ? Data_X : Data_Y;
            swap_o     <= swap;
            real_op_o  <= real_op;
            sign_res_o <= sign_res;
         end
      end
   end

`ifdef FPADDSUB_ZERO_DETECT_EN
   // Exact zero: both operands are zero, or equal magnitudes cancel under subtraction.
   always_ff @(posedge clk) begin
      if (rst) begin
         zero_res_o <= 1'b0;
      end else if (load) begin
         zero_res_o <= ((mag_x == '0) && (mag_y == '0)) || (real_op && (mag_x == mag_y));
      end
   end
`else
   assign zero_res_o = 1'b0;
`endif

endmodule
